// File: rtl/tlul_mem_slave_if.sv
// TL-UL A/D channel bundle between a host (master) and a memory endpoint (slave).
// Carries the request and response fields only; clock and reset stay plain ports.
interface tlul_mem_slave_if #(
   parameter int DATA_W = 32,
   parameter int SRC_W  = 3
);
   logic                  a_valid;
   logic                  a_ready;
   logic [2:0]            a_opcode;
   logic [2:0]            a_param;
   logic [3:0]            a_size;
   logic [DATA_W/8-1:0]   a_mask;
   logic [31:0]           a_address;
   logic [DATA_W-1:0]     a_data;
   logic [SRC_W-1:0]      a_source;
   logic                  d_valid;
   logic                  d_ready;
   logic [2:0]            d_opcode;
   logic [2:0]            d_param;
   logic [3:0]            d_size;
   logic [SRC_W-1:0]      d_source;
   logic [1:0]            d_sink;
   logic [DATA_W-1:0]     d_data;
   logic                  d_error;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_mask, a_address, a_data, a_source, d_ready,
      input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_mask, a_address, a_data, a_source, d_ready,
      output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
   );
endinterface

// File: rtl/tlul_mem_slave.sv
// TL-UL leaf slave backed by a word-addressed memory, with a small response FIFO
// so requests keep being accepted while the D channel is back-pressured.
module tlul_mem_slave #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 256,
   parameter int SRC_W     = 3,
   parameter int RSP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   tlul_mem_slave_if.slave   bus
);
   localparam int MASK_W   = DATA_W / 8;
   localparam int OFF      = $clog2(MASK_W);
   localparam int IDX_BITS = $clog2(DEPTH);
   localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
   localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W    = $clog2(RSP_DEPTH + 1);

   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_GET      = 3'd4;
   localparam logic [2:0] OP_ACK      = 3'd0;
   localparam logic [2:0] OP_ACK_DATA = 3'd1;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [3:0]        size;
      logic [SRC_W-1:0]  source;
      logic [DATA_W-1:0] data;
      logic              error;
   } rsp_t;

   function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < MASK_W; i++) begin
         r[i*8 +: 8] = {8{m[i]}};
      end
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RSP_DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   logic [DATA_W-1:0] mem_r [DEPTH];
   rsp_t              fifo_r [RSP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;

   logic              a_ready_s;
   logic              d_valid_s;
   logic              push_s;
   logic              pop_s;
   logic              op_ok_s;
   logic              is_get_s;
   logic              err_s;
   logic [IDX_W-1:0]  idx_s;
   logic [31:0]       hi_bits_s;
   logic [31:0]       lo_bits_s;
   rsp_t              entry_s;
   rsp_t              out_s;
   logic              unused_param_s;

   assign unused_param_s = ^bus.a_param;

   // a_ready depends only on the registered count, never on d_ready
   assign a_ready_s = (count_r < CNT_W'(RSP_DEPTH));
   assign d_valid_s = (count_r != '0);
   assign push_s    = bus.a_valid && a_ready_s;
   assign pop_s     = d_valid_s && bus.d_ready;

   assign hi_bits_s = bus.a_address >> (OFF + IDX_BITS);
   assign lo_bits_s = bus.a_address & ((32'd1 << OFF) - 32'd1);
   assign idx_s     = (IDX_BITS > 0) ? bus.a_address[OFF +: IDX_W] : '0;

   // Request decode and the response entry it produces
   always_comb begin
      op_ok_s  = 1'b0;
      is_get_s = 1'b0;
      case (bus.a_opcode)
         OP_PUT_FULL, OP_PUT_PART: op_ok_s = 1'b1;
         OP_GET: begin
            op_ok_s  = 1'b1;
            is_get_s = 1'b1;
         end
         default: op_ok_s = 1'b0;
      endcase
      err_s = !op_ok_s || (hi_bits_s != 32'd0) || (lo_bits_s != 32'd0);

      entry_s        = '0;
      entry_s.size   = bus.a_size;
      entry_s.source = bus.a_source;
      entry_s.error  = err_s;
      if (is_get_s) begin
         entry_s.opcode = OP_ACK_DATA;
      end else begin
         entry_s.opcode = OP_ACK;
      end
      if (is_get_s && !err_s) begin
         entry_s.data = mem_r[idx_s] & expand_mask(bus.a_mask);
      end else begin
         entry_s.data = '0;
      end
   end

   // Byte-masked memory write for error-free Puts; memory is never reset
   always_ff @(posedge clk) begin
      if (push_s && !err_s && !is_get_s) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (bus.a_mask[i]) begin
               mem_r[idx_s][i*8 +: 8] <= bus.a_data[i*8 +: 8];
            end
         end
      end
   end

   // Response FIFO storage; stale entries are hidden by the count
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_r[wr_ptr_r] <= entry_s;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // D-channel fields show the head entry, all zero while empty
   always_comb begin
      if (d_valid_s) begin
         out_s = fifo_r[rd_ptr_r];
      end else begin
         out_s = '0;
      end
   end

   assign bus.a_ready  = a_ready_s;
   assign bus.d_valid  = d_valid_s;
   assign bus.d_opcode = out_s.opcode;
   assign bus.d_param  = 3'd0;
   assign bus.d_size   = out_s.size;
   assign bus.d_source = out_s.source;
   assign bus.d_sink   = 2'd0;
   assign bus.d_data   = out_s.data;
   assign bus.d_error  = out_s.error;
endmodule

// File: doc/tlul_mem_slave.md
# tlul_mem_slave

Parametrised TL-UL slave backed by a word-addressed memory array. It supports Get, PutFullData and PutPartialData, applies byte masks, and flags unsupported or out-of-range accesses with d_error. A small response FIFO decouples the A and D channels, so the slave keeps accepting requests while responses are back-pressured. The block sits as a leaf endpoint behind the TL-UL crossbar and replaces the fixed-pattern Get-only slave.

## Interface
- DATA_W, 32: data width in bits; multiple of 8, at least 8.
- DEPTH, 256: memory words; power of 2.
- SRC_W, 3: source ID width.
- RSP_DEPTH, 2: response FIFO entries; power of 2, at least 1.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- a_valid / a_ready  in / out  1  A-channel handshake.
- a_opcode  in  3  request opcode: 0 PutFullData, 1 PutPartialData, 4 Get.
- a_param  in  3  ignored.
- a_size  in  4  log2 of the byte count; echoed on d_size.
- a_mask  in  DATA_W/8  byte enables.
- a_address  in  32  byte address.
- a_data  in  DATA_W  write data.
- a_source  in  SRC_W  request ID.
- d_valid / d_ready  out / in  1  D-channel handshake.
- d_opcode  out  3  response opcode: 0 AccessAck, 1 AccessAckData.
- d_param  out  3  constant 0.
- d_size  out  4  echo of a_size.
- d_source  out  SRC_W  echo of a_source.
- d_sink  out  2  constant 0.
- d_data  out  DATA_W  read data; 0 for Puts and errors.
- d_error  out  1  request rejected.

## Operation
- OFF = log2(DATA_W/8).
- Word index = a_address[OFF+log2(DEPTH)-1 : OFF].
- A request is an error if any of these holds:
  - a_opcode is not 0, 1 or 4;
  - any a_address bit at or above OFF+log2(DEPTH) is set;
  - a_address[OFF-1:0] is nonzero.
- Accept condition: a_valid && a_ready. Each accepted request pushes exactly one FIFO entry {opcode, size, source, data, error}.
- Put, no error: on the accept edge, write each byte i of the addressed word with a_data byte i where a_mask[i]=1. Bytes with a_mask[i]=0 are unchanged. PutFullData uses the same masking as PutPartialData.
- Put response: d_opcode=0, d_data=0.
- Get, no error: read the addressed word on the accept edge and store it in the FIFO entry, with byte i forced to 0 where a_mask[i]=0. Response: d_opcode=1.
- Error response: no memory write. d_data=0, d_error=1. d_opcode=1 if the request was a Get, otherwise 0.
- Responses leave in acceptance order (FIFO). d_* fields show the head entry.
- Memory is not reset. Contents are undefined until written.

## Timing
- Reset values:
  - FIFO empty, count 0, so d_valid=0 and a_ready=1.
  - d_opcode, d_param, d_size, d_source, d_sink, d_data and d_error are all 0 while empty.
  - Memory is untouched by reset.
- a_ready = (count < RSP_DEPTH). It is a registered-count function, not combinational on d_ready. When full, a_ready stays 0 during a cycle with a pop; it rises the cycle after.
- d_valid = (count != 0).
- Latency: a request accepted at edge N is visible on D from cycle N+1 if the FIFO was empty.
- Simultaneous push and pop: count is unchanged and pointers advance. Pointers wrap modulo RSP_DEPTH.
- d_* fields stay stable while d_valid=1 and d_ready=0.
- Read-after-write:
  - A Get accepted at a later edge than a Put to the same word returns the new data.
  - Requests cannot be accepted on the same edge, since there is only one A beat per cycle.
- Asynchronous reset mid-operation empties the FIFO immediately and drops pending responses. Memory writes already committed persist.

## Test plan
- Reset, then PutFullData addr 0x10, data 0xDEADBEEF, mask 0xF, source 2 -> next cycle d_valid=1, d_opcode=0, d_source=2, d_error=0, d_data=0. Then Get addr 0x10, mask 0xF -> d_opcode=1, d_data=0xDEADBEEF.
- PutPartialData addr 0x10, data 0x11223344, mask 0x5 over 0xDEADBEEF -> Get mask 0xF returns 0xDE22BE44. Get mask 0x3 returns 0x0000BE44.
- Hold d_ready=0 with RSP_DEPTH=2, issue 3 Gets with sources 1, 2, 3 -> two accepted, then a_ready=0. Release d_ready -> responses arrive with sources 1, 2, then the third is accepted one cycle after the first pop.
- Get addr 0x400 (DEPTH=256), Get addr 0x13, and opcode 2 -> each gives d_error=1 and d_data=0, with d_opcode 1, 1 and 0 respectively. Memory is unchanged.
- Back-to-back Gets with d_ready=1 continuously -> one response per cycle, with count never exceeding 1.
- Assert rst_n low with 2 responses pending -> d_valid=0 and a_ready=1 immediately. After release, a Get of a previously written word returns the written data.
